// File: rtl/mux2_arb_if.sv
// Bundle of request, data, grant and output signals for the two-requester arbitrated mux.
// The master side drives the requests and data; the slave side is the arbiter itself.
interface mux2_arb_if #(
  parameter int DATA_W = 1
);
  logic              req_1;
  logic              req_2;
  logic [DATA_W-1:0] in_1;
  logic [DATA_W-1:0] in_2;
  logic              gnt_1;
  logic              gnt_2;
  logic              sel;
  logic [DATA_W-1:0] out;
  logic              out_vld;

  modport master (
    output req_1, req_2, in_1, in_2,
    input  gnt_1, gnt_2, sel, out, out_vld
  );

  modport slave (
    input  req_1, req_2, in_1, in_2,
    output gnt_1, gnt_2, sel, out, out_vld
  );
endinterface

// File: rtl/mux2_arb.sv
// Two-requester arbitrated mux with a fair tie-break and bounded hold under contention.
// Grants, select and data are all registered; data trails the grant by one cycle.
module mux2_arb #(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 8
) (
  input logic       sys_clk,
  input logic       sys_rst_n,
  mux2_arb_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN1 = 2'd1,
    OWN2 = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  state_t            state_r;
  state_t            state_nxt;
  logic [7:0]        hold_cnt_r;
  logic [7:0]        hold_nxt;
  logic [1:0]        last_srv_r;
  logic              both_s;
  logic              gnt_1_r;
  logic              gnt_2_r;
  logic              sel_r;
  logic [DATA_W-1:0] out_r;
  logic              out_vld_r;

  // Next-state arbitration and hold-counter update.
  always_comb begin
    both_s    = bus.req_1 & bus.req_2;
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (both_s) begin
          state_nxt = (last_srv_r == 2'd1) ? OWN2 : OWN1;
        end else if (bus.req_1) begin
          state_nxt = OWN1;
        end else if (bus.req_2) begin
          state_nxt = OWN2;
        end else begin
          state_nxt = IDLE;
        end
      end
      OWN1: begin
        if (bus.req_1) begin
          state_nxt = (bus.req_2 && (hold_cnt_r == HOLD_LIM)) ? OWN2 : OWN1;
        end else if (bus.req_2) begin
          state_nxt = OWN2;
        end else begin
          state_nxt = IDLE;
        end
      end
      OWN2: begin
        if (bus.req_2) begin
          state_nxt = (bus.req_1 && (hold_cnt_r == HOLD_LIM)) ? OWN1 : OWN2;
        end else if (bus.req_1) begin
          state_nxt = OWN1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Counts only while the owner keeps the mux and the other side is waiting.
    if ((state_nxt == state_r) && (state_r != IDLE) && both_s) begin
      hold_nxt = hold_cnt_r + 8'd1;
    end else begin
      hold_nxt = 8'd0;
    end
  end

  // FSM state, fairness flag and all registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r    <= IDLE;
      hold_cnt_r <= 8'd0;
      last_srv_r <= 2'd2;
      gnt_1_r    <= 1'b0;
      gnt_2_r    <= 1'b0;
      sel_r      <= 1'b0;
      out_r      <= '0;
      out_vld_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      hold_cnt_r <= hold_nxt;
      gnt_1_r    <= (state_nxt == OWN1);
      gnt_2_r    <= (state_nxt == OWN2);
      if (state_nxt != state_r) begin
        case (state_nxt)
          OWN1:    last_srv_r <= 2'd1;
          OWN2:    last_srv_r <= 2'd2;
          default: last_srv_r <= last_srv_r;
        endcase
      end
      case (state_nxt)
        OWN1:    sel_r <= 1'b0;
        OWN2:    sel_r <= 1'b1;
        default: sel_r <= sel_r;
      endcase
      // Data uses the grant/select already visible, hence the one-cycle trail.
      if (gnt_1_r || gnt_2_r) begin
        out_r     <= sel_r ? bus.in_2 : bus.in_1;
        out_vld_r <= 1'b1;
      end else begin
        out_vld_r <= 1'b0;
      end
    end
  end

  assign bus.gnt_1   = gnt_1_r;
  assign bus.gnt_2   = gnt_2_r;
  assign bus.sel     = sel_r;
  assign bus.out     = out_r;
  assign bus.out_vld = out_vld_r;
endmodule

// File: tb/tb_mux2_arb.sv
// Directed and randomized bench for mux2_arb against an owner/streak reference model;
// a second instance with MAX_HOLD = 1 exercises per-cycle alternation.
module tb_mux2_arb;
  localparam int DW = 4;
  localparam int MH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux2_arb_if #(.DATA_W(DW)) b0 ();
  mux2_arb_if #(.DATA_W(DW)) b1 ();

  mux2_arb #(.DATA_W(DW), .MAX_HOLD(MH)) u0 (.sys_clk(clk), .sys_rst_n(rst_n), .bus(b0));
  mux2_arb #(.DATA_W(DW), .MAX_HOLD(1))  u1 (.sys_clk(clk), .sys_rst_n(rst_n), .bus(b1));

  int n_chk = 0;
  int n_fail = 0;

  // reference model: who owns the mux, who was served last, how long the owner has made the other wait
  int          m_owner;
  int          m_last;
  int          m_streak;
  logic          m_sel;
  logic [DW-1:0] m_out;
  logic          m_vld;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_last = 2; m_streak = 0;
    m_sel = 1'b0; m_out = '0; m_vld = 1'b0;
  endtask

  task automatic model_step(input logic r1, input logic r2, input logic [DW-1:0] i1, input logic [DW-1:0] i2);
    int nxt;
    bit mine, other;
    if (m_owner != 0) begin
      m_out = m_sel ? i2 : i1;
      m_vld = 1'b1;
    end else begin
      m_vld = 1'b0;
    end
    if (m_owner == 0) begin
      if (r1 && r2)  nxt = (m_last == 1) ? 2 : 1;
      else if (r1)   nxt = 1;
      else if (r2)   nxt = 2;
      else           nxt = 0;
    end else begin
      mine  = (m_owner == 1) ? r1 : r2;
      other = (m_owner == 1) ? r2 : r1;
      if (mine && other) nxt = (m_streak == MH - 1) ? 3 - m_owner : m_owner;
      else if (mine)     nxt = m_owner;
      else if (other)    nxt = 3 - m_owner;
      else               nxt = 0;
    end
    m_streak = (nxt == m_owner && nxt != 0 && r1 && r2) ? m_streak + 1 : 0;
    if (nxt != 0 && nxt != m_owner) m_last = nxt;
    if (nxt != 0) m_sel = (nxt == 2);
    m_owner = nxt;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".gnt_1"},  32'(b0.gnt_1),   32'(m_owner == 1));
    check({tag, ".gnt_2"},  32'(b0.gnt_2),   32'(m_owner == 2));
    check({tag, ".sel"},    32'(b0.sel),     32'(m_sel));
    check({tag, ".out"},    32'(b0.out),     32'(m_out));
    check({tag, ".out_vld"},32'(b0.out_vld), 32'(m_vld));
    check({tag, ".excl"},   32'(b0.gnt_1 & b0.gnt_2), 32'd0);
  endtask

  task automatic cycle(input logic r1, input logic r2, input logic [DW-1:0] i1, input logic [DW-1:0] i2, input string tag);
    b0.req_1 = r1; b0.req_2 = r2; b0.in_1 = i1; b0.in_2 = i2;
    model_step(r1, r2, i1, i2);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] held_out;
    b0.req_1 = 1'b0; b0.req_2 = 1'b0; b0.in_1 = '0; b0.in_2 = '0;
    b1.req_1 = 1'b0; b1.req_2 = 1'b0; b1.in_1 = '0; b1.in_2 = '0;
    model_reset();
    #12;
    check("rst.gnt_1", 32'(b0.gnt_1), 32'd0);
    check("rst.gnt_2", 32'(b0.gnt_2), 32'd0);
    check("rst.sel",   32'(b0.sel),   32'd0);
    check("rst.out",   32'(b0.out),   32'd0);
    check("rst.vld",   32'(b0.out_vld), 32'd0);
    rst_n = 1'b1;

    // lone requester 1: grant after one edge, data after two
    cycle(1'b1, 1'b0, 4'd1, 4'd0, "lone_a");
    check("lone_gnt_1", 32'(b0.gnt_1), 32'd1);
    cycle(1'b1, 1'b0, 4'd1, 4'd0, "lone_b");
    check("lone_out", 32'(b0.out), 32'd1);
    check("lone_vld", 32'(b0.out_vld), 32'd1);
    check("lone_sel", 32'(b0.sel), 32'd0);

    // contention after reset: requester 1 first, preempted every MAX_HOLD cycles
    pulse_reset();
    for (int k = 1; k <= 17; k++) begin
      cycle(1'b1, 1'b1, 4'($urandom), 4'($urandom), "tie");
      if (k == 1 || k == 8) check("tie_gnt_1_early", 32'(b0.gnt_1), 32'd1);
      if (k == 9) begin
        check("tie_gnt_2", 32'(b0.gnt_2), 32'd1);
        check("tie_sel",   32'(b0.sel),   32'd1);
      end
      if (k == 17) check("tie_gnt_1_again", 32'(b0.gnt_1), 32'd1);
    end

    // owner drops with the other waiting: direct handover
    cycle(1'b0, 1'b1, 4'h3, 4'hc, "handover");
    check("handover_gnt_2", 32'(b0.gnt_2), 32'd1);
    check("handover_vld", 32'(b0.out_vld), 32'd1);
    cycle(1'b0, 1'b1, 4'h5, 4'ha, "handover2");
    check("handover_vld2", 32'(b0.out_vld), 32'd1);

    // both drop: idle, then valid falls with out and sel held
    cycle(1'b0, 1'b0, 4'h6, 4'h9, "drop_a");
    check("drop_gnt_2", 32'(b0.gnt_2), 32'd0);
    held_out = b0.out;
    cycle(1'b0, 1'b0, 4'h1, 4'h2, "drop_b");
    check("drop_vld", 32'(b0.out_vld), 32'd0);
    check("drop_out_held", 32'(b0.out), 32'(held_out));
    check("drop_sel_held", 32'(b0.sel), 32'd1);

    // asynchronous reset in the middle of an OWN2 cycle
    cycle(1'b0, 1'b1, 4'h7, 4'hb, "own2_a");
    cycle(1'b0, 1'b1, 4'h7, 4'hb, "own2_b");
    #3;
    rst_n = 1'b0;
    #1;
    check("async_gnt_2", 32'(b0.gnt_2), 32'd0);
    check("async_sel",   32'(b0.sel),   32'd0);
    check("async_out",   32'(b0.out),   32'd0);
    check("async_vld",   32'(b0.out_vld), 32'd0);
    model_reset();
    #2;
    rst_n = 1'b1;
    cycle(1'b0, 1'b1, 4'h4, 4'he, "post_rst");
    check("post_rst_gnt_2", 32'(b0.gnt_2), 32'd1);

    // single-cycle pulse yields exactly one grant cycle
    cycle(1'b0, 1'b0, 4'h0, 4'h0, "pulse_idle_a");
    cycle(1'b0, 1'b0, 4'h0, 4'h0, "pulse_idle_b");
    cycle(1'b1, 1'b0, 4'h8, 4'h0, "pulse_on");
    check("pulse_gnt", 32'(b0.gnt_1), 32'd1);
    cycle(1'b0, 1'b0, 4'h0, 4'h0, "pulse_off");
    check("pulse_gnt_gone", 32'(b0.gnt_1), 32'd0);

    // randomized traffic, requests biased high to provoke contention
    for (int n = 0; n < 10000; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            4'($urandom), 4'($urandom), "rand");
    end

    // MAX_HOLD = 1 under continuous contention alternates every cycle
    b1.req_1 = 1'b1;
    b1.req_2 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      check("alt_gnt_1", 32'(b1.gnt_1), 32'((k % 2) == 0));
      check("alt_gnt_2", 32'(b1.gnt_2), 32'((k % 2) == 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mux2_arb.md
MUX2_ARB -- requirements
Module: mux2_arb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 1, giving the width of each data input and of out.
REQ-002 The block SHALL have parameter MAX_HOLD, default 8, legal range 1..255, giving the maximum number of cycles a grant is held while the other requester waits.
REQ-003 Port sys_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port sys_rst_n  input  1  the reset; asynchronous and active-low.
REQ-005 Port req_1  input  1  requester 1 asks for the mux; level-sensitive.
REQ-006 Port req_2  input  1  requester 2 asks for the mux; level-sensitive.
REQ-007 Port in_1  input  DATA_W  data from requester 1.
REQ-008 Port in_2  input  DATA_W  data from requester 2.
REQ-009 Port gnt_1  output  1  requester 1 owns the mux; registered.
REQ-010 Port gnt_2  output  1  requester 2 owns the mux; registered.
REQ-011 Port sel  output  1  mux select (0 = in_1, 1 = in_2); registered.
REQ-012 Port out  output  DATA_W  registered mux output.
REQ-013 Port out_vld  output  1  out carries granted data; registered.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, OWN1 and OWN2.
REQ-015 gnt_1 SHALL be 1 only in OWN1, gnt_2 SHALL be 1 only in OWN2, and both SHALL never be 1 together.
REQ-016 From IDLE, a lone req_1 SHALL go to OWN1 and a lone req_2 SHALL go to OWN2, with grant visible the cycle after the req is sampled (1-cycle latency).
REQ-017 From IDLE with both requests high, the FSM SHALL grant the requester not served last, using the flag last_srv.
REQ-018 In OWNx with req_x still high, the grant SHALL be held, except as required by REQ-021.
REQ-019 In OWNx with req_x low and the other request high, the FSM SHALL go directly to the other OWN state, with no IDLE bubble.
REQ-020 In OWNx with both requests low, the FSM SHALL go to IDLE.
REQ-021 Hold counter hold_cnt (8 bit):
  - SHALL increment each OWNx cycle in which req_x and the other request are both high;
  - SHALL clear on any state change and whenever the other request is low;
  - when hold_cnt == MAX_HOLD-1 and both requests remain high, the FSM SHALL switch to the other OWN state on the next edge (preemption).
REQ-022 With MAX_HOLD = 1 under continuous contention, the grant SHALL alternate every cycle.
REQ-023 last_srv SHALL update to x on every entry into OWNx.
REQ-024 sel SHALL be 0 in OWN1 and 1 in OWN2, and SHALL hold its last value in IDLE.
REQ-025 When gnt_1 or gnt_2 is high, each edge SHALL load out with (sel ? in_2 : in_1) and set out_vld to 1; data therefore trails grant by one cycle.
REQ-026 In IDLE, out SHALL hold its value and out_vld SHALL be 0 on the next edge.
REQ-027 A request pulse lasting one cycle SHALL still produce exactly one grant cycle.

Reset
REQ-028 While sys_rst_n = 0, regardless of clock, the block SHALL hold: state = IDLE; gnt_1 = 0; gnt_2 = 0; sel = 0; out = 0; out_vld = 0; hold_cnt = 0; last_srv = 2.
REQ-029 Because last_srv resets to 2, the first tie after reset SHALL go to requester 1.
REQ-030 Reset asserted mid-grant SHALL drop the grant and out_vld immediately.
REQ-031 After reset release, the first arbitration SHALL occur on the first rising edge with sys_rst_n = 1.

Verification
REQ-032 Reset, then req_1 = 1, req_2 = 0, in_1 = 1 -> gnt_1 = 1 after 1 edge; out = 1 and out_vld = 1 after 2 edges; sel = 0.
REQ-033 Both requests rise together after reset -> gnt_1 first; after 8 cycles (MAX_HOLD = 8) gnt_2 = 1 and sel = 1; after 8 more cycles gnt_1 again.
REQ-034 In OWN1, drop req_1 while req_2 = 1 -> gnt_2 = 1 on the next edge with no IDLE cycle; out_vld stays 1 throughout.
REQ-035 Both requests low while granted -> IDLE next edge; out_vld = 0 one edge later; out and sel unchanged.
REQ-036 Assert sys_rst_n = 0 mid-OWN2 between edges -> gnt_2, sel, out and out_vld all 0 at once; after release with req_2 = 1, gnt_2 = 1 after 1 edge.
REQ-037 Random req_1, req_2, in_1, in_2 every 10 ns for 10,000 cycles -> never gnt_1 & gnt_2; out always equals the selected input from the prior edge when out_vld = 1.
